// File: rtl/product_bcd_display.sv
// product_bcd_display
//   Takes the 8-bit unsigned product from the 4x4 multiplier over a valid/ready
//   handshake. It converts the product to packed BCD with a sequential double-dabble
//   engine that handles one bit per cycle. The result is shown as registered,
//   active-low 7-segment codes.
// Ports
//   clk, rst              clock (rising edge); asynchronous active-high reset
//   in_valid/in_ready     input handshake; in_ready is high only while idle
//   in_data               unsigned binary value to convert
//   out_valid/out_ready   output handshake; out_valid is high while a result waits
//   out_bcd               packed BCD, digit 0 in [3:0]
//   seg                   active-low {g,f,e,d,c,b,a} per digit, digit 0 in [6:0]
//   busy                  high while converting
module product_bcd_display #(
    parameter int IN_WIDTH = 8,
    parameter int DIGITS   = 3,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_WIDTH-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  busy
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = 7 * DIGITS;
    localparam int CW = $clog2(IN_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Walk from the most significant digit down. 'lead' stays set while every digit
    // seen so far is zero. Digit 0 is always shown.
    function automatic logic [SW-1:0] seg_of(input logic [BW-1:0] bcd);
        logic [SW-1:0] s;
        logic          lead;
        s    = '0;
        lead = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (bcd[4*k +: 4] != 4'd0) lead = 1'b0;
            if (BLANK_LZ && (k > 0) && lead) s[7*k +: 7] = 7'b1111111;
            else                             s[7*k +: 7] = seg7(bcd[4*k +: 4]);
        end
        return s;
    endfunction

    localparam logic [SW-1:0] SEG_RST = seg_of('0);

    state_t              state_q, state_d;
    logic [IN_WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]       scr_q, scr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BW-1:0]       bcd_q, bcd_d;
    logic [SW-1:0]       seg_q, seg_d;
    logic [BW-1:0]       adj;
    logic [BW-1:0]       scr_nxt;

    always_comb begin
        // Per-digit +3 correction. The 4-bit add cannot carry, because a digit is <= 9 here.
        adj = scr_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (scr_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
        end
        scr_nxt = {adj[BW-2:0], shift_q[IN_WIDTH-1]};

        state_d = state_q;
        shift_d = shift_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        seg_d   = seg_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d = in_data;
                    scr_d   = '0;
                    cnt_d   = CW'(IN_WIDTH);
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                scr_d   = scr_nxt;
                shift_d = {shift_q[IN_WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d   = scr_nxt;
                    seg_d   = seg_of(scr_nxt);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            seg_q   <= SEG_RST;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            seg_q   <= seg_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == CONVERT);
    assign out_valid = (state_q == DONE);
    assign out_bcd   = bcd_q;
    assign seg       = seg_q;

endmodule
